aes_top: RTL and testbench

AES_TOP -- requirements
Module: aes_top

---
 rtl/aes_top.sv | 159 +++++++++++++++
 tb/tb_aes_top.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/aes_top.sv
// AES-128 encryption core, iterative: one round per clock, key expanded on the fly.
// Latency: 10 edges from the capture edge to the edge raising AES_data_out_valid; one result per 11 cycles.
// Backpressure: none; AES_en is sampled only while idle and the valid pulse is never stalled.
// Ports: AES_clk/AES_rst_n clock and async active-low reset; AES_en level start request;
//        AES_data_in/AES_key_in 128-bit plaintext and key (bits [127:120] are byte 0);
//        AES_data_out registered ciphertext, held until the next completion; AES_data_out_valid 1-cycle pulse.
module aes_top (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    // Forward S-box, entry 0 in the top byte so entry x sits at bit offset 8*(255-x) = 8*~x.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, RUN} fsm_e;

    fsm_e         fsm_q;
    logic [3:0]   rnd_q;
    logic [127:0] state_q;
    logic [127:0] rkey_q;

    logic [127:0] sb_d, sr_d, mc_d, rkey_d, round_d, final_d;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte n lives at [127-8n -: 8]; byte n is row n%4, column n/4.
    // Row r of column c takes row r of column (c+r)%4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Next round key from the current one: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon, then chained XORs.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, tmp;
        w0  = rkey_q[127:96];
        w1  = rkey_q[95:64];
        w2  = rkey_q[63:32];
        w3  = rkey_q[31:0];
        tmp = {sbox(w3[23:16]) ^ rcon(rnd_q), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0  = w0 ^ tmp;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        rkey_d = {w0, w1, w2, w3};
    end

    always_comb begin
        sb_d    = sub_bytes(state_q);
        sr_d    = shift_rows(sb_d);
        mc_d    = mix_columns(sr_d);
        round_d = mc_d ^ rkey_d;
        final_d = sr_d ^ rkey_d;
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm_q              <= IDLE;
            rnd_q              <= 4'd0;
            state_q            <= '0;
            rkey_q             <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            AES_data_out_valid <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (AES_en) begin
                        state_q <= AES_data_in ^ AES_key_in;
                        rkey_q  <= AES_key_in;
                        rnd_q   <= 4'd1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    rkey_q <= rkey_d;
                    if (rnd_q == 4'd10) begin
                        state_q            <= final_d;
                        AES_data_out       <= final_d;
                        AES_data_out_valid <= 1'b1;
                        rnd_q              <= 4'd0;
                        fsm_q              <= IDLE;
                    end else begin
                        state_q <= round_d;
                        rnd_q   <= rnd_q + 4'd1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_top.sv
module tb_aes_top;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [127:0] din;
    logic [127:0] kin;
    logic [127:0] dout;
    logic         dvld;

    aes_top dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (dvld)
    );

    typedef struct {
        logic [127:0] dat;
        int           edge_idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] JUNK = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: every valid pulse must match the oldest expected entry, both data and arrival edge.
    always @(negedge clk) begin
        if (rst_n && dvld) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: edge=%0d data=%h, no result outstanding", edge_n, dout);
            end else begin
                mon_e = sb_q.pop_front();
                total++;
                if (dout !== mon_e.dat) begin
                    bad++;
                    $display("FAIL result_data: got %h want %h", dout, mon_e.dat);
                end
                total++;
                if (edge_n != mon_e.edge_idx) begin
                    bad++;
                    $display("FAIL result_latency: valid at edge %0d want edge %0d", edge_n, mon_e.edge_idx);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Called just after a negedge with en about to be seen at the next posedge (capture edge).
    task automatic start(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c);
        exp_t e;
        en  = 1'b1;
        din = p;
        kin = k;
        e.dat = c;
        e.edge_idx = edge_n + 11;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding after %0d cycles, want 0", sb_q.size(), max_cycles);
            sb_q.delete();
        end
    endtask

    task automatic single(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c, input string name);
        @(negedge clk);
        start(p, k, c);
        @(negedge clk);
        // Inputs change mid-operation; the result must not care.
        en  = 1'b0;
        din = JUNK;
        kin = ~JUNK;
        wait_drain(20);
        @(negedge clk);
        check({name, "_hold"}, dout, c);
        check({name, "_vld_low"}, {127'd0, dvld}, 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        din   = '0;
        kin   = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_data", dout, 128'd0);
        check("reset_vld", {127'd0, dvld}, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        single(P1, K1, C1, "fips_c1");
        single(P2, K2, C2, "fips_b");
        single(128'd0, 128'd0, C3, "zero");

        // Continuous enable for 51 edges: captures at offsets 0,11,22,33,44 from the first.
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            exp_t e;
            e.dat = C2;
            e.edge_idx = edge_n + 11 + 11 * j;
            sb_q.push_back(e);
        end
        en  = 1'b1;
        kin = K2;
        for (int i = 0; i < 51; i++) begin
            din = ((i % 11) >= 3 && (i % 11) <= 7) ? JUNK : P2;
            @(negedge clk);
        end
        en  = 1'b0;
        din = P2;
        wait_drain(30);

        // Idle with en low: input changes must not produce a pulse or disturb the output.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            din = JUNK ^ {96'd0, 32'(i)};
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("idle_hold", dout, C2);

        // Reset at E5 aborts the operation with no pulse.
        @(negedge clk);
        start(P1, K1, C1);
        @(posedge clk);
        #1 en = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check("abort_data", dout, 128'd0);
        check("abort_vld", {127'd0, dvld}, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_pulse_data", dout, 128'd0);

        single(128'd0, 128'd0, C3, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
